// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: shares one Avalon-MM slave bus between an instruction and a data master
module avalon_bus_arbiter #(
  parameter int PRIORITY_MODE = 0,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;
  state_t state, state_nxt;
  logic last_grant, last_grant_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic req0, req1, busy, sel, s_read, s_write, s_req, other_req, at_limit, abort, done, handoff;
  // Bus mux, master responses and arbitration; the timeout gate on the strobes uses only the
  // registered counter so waitrequest never reaches the bus strobes, and the abort fires on the
  // counter alone because the memory saw no strobe in that cycle
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    busy = state != IDLE;
    sel = state == BUSY1;
    s_read = sel ? m1_read : m0_read;
    s_write = sel ? m1_write : m0_write;
    s_req = s_read | s_write;
    other_req = sel ? req0 : req1;
    at_limit = busy && TIMEOUT > 0 && cnt == 16'(TIMEOUT - 1);
    abort = at_limit && s_req;
    address = busy ? (sel ? m1_address : m0_address) : '0;
    writedata = busy ? (sel ? m1_writedata : m0_writedata) : '0;
    byteenable = busy ? (sel ? m1_byteenable : m0_byteenable) : '0;
    write = busy && !at_limit && s_write;
    read = busy && !at_limit && s_read && !s_write;
    done = (read || write) && !waitrequest;
    grant = {state == BUSY1, state == BUSY0};
    m0_waitrequest = state == BUSY0 ? (abort ? 1'b0 : waitrequest) : 1'b1;
    m1_waitrequest = state == BUSY1 ? (abort ? 1'b0 : waitrequest) : 1'b1;
    m0_readdata = state == BUSY0 ? (abort ? 32'hDEADBEEF : readdata) : '0;
    m1_readdata = state == BUSY1 ? (abort ? 32'hDEADBEEF : readdata) : '0;
    handoff = other_req && (PRIORITY_MODE == 0 || sel);
    state_nxt = !busy ? ((req0 && (!req1 || PRIORITY_MODE != 0 || last_grant)) ? BUSY0 : req1 ? BUSY1 : IDLE)
              : (abort || !s_req) ? IDLE
              : done ? (handoff ? (sel ? BUSY0 : BUSY1) : IDLE)
              : state;
    last_grant_nxt = (abort || done) ? sel : last_grant;
    cnt_nxt = (busy && state_nxt == state) ? (cnt == 16'hFFFF ? cnt : cnt + 16'd1) : '0;
  end
  // State, fairness pointer, stall counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last_grant <= 1'b1;
      cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt <= cnt_nxt;
      timeout_err <= timeout_err | abort;
    end
  end
endmodule
